// File: rtl/spi_shift_ctrl_pkg.sv
// Shared defaults and state encoding for the SPI
// master transfer controller.
package spi_shift_ctrl_pkg;

   localparam int SPI_MAX_CHAR_DEF      = 32;
   localparam int SPI_CHAR_LEN_BITS_DEF = 5;

   typedef enum logic {
      SPI_ST_IDLE = 1'b0,
      SPI_ST_BUSY = 1'b1
   } spi_st_e;

endpackage

// File: rtl/spi_shift_ctrl.sv
// SPI master transfer controller: drives MOSI and
// samples MISO on strobes from the clock generator.
module spi_shift_ctrl
   import spi_shift_ctrl_pkg::*;
#(
   parameter int SPI_MAX_CHAR      = SPI_MAX_CHAR_DEF,
   parameter int SPI_CHAR_LEN_BITS = SPI_CHAR_LEN_BITS_DEF
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_go,
   input  logic [SPI_CHAR_LEN_BITS-1:0] i_char_len,
   input  logic                         i_lsb,
   input  logic                         i_tx_neg,
   input  logic                         i_rx_neg,
   input  logic                         i_pos_edge,
   input  logic                         i_neg_edge,
   input  logic [SPI_MAX_CHAR-1:0]      i_tx_data,
   input  logic                         i_miso,
   output logic                         o_tx_start,
   output logic                         o_last_clk,
   output logic                         o_busy,
   output logic                         o_done,
   output logic [SPI_MAX_CHAR-1:0]      o_rx_data,
   output logic                         o_mosi
);

   localparam int CW = SPI_CHAR_LEN_BITS + 1;

   typedef logic [CW-1:0]                cnt_t;
   typedef logic [SPI_CHAR_LEN_BITS-1:0] idx_t;

   spi_st_e                 state;
   cnt_t                    len;
   cnt_t                    tx_cnt;
   cnt_t                    rx_cnt;
   logic                    lsb;
   logic                    tx_neg;
   logic                    rx_neg;
   logic [SPI_MAX_CHAR-1:0] tx_buf;
   logic [SPI_MAX_CHAR-1:0] rx_buf;

   logic                    busy;
   logic                    tx_fire;
   logic                    rx_fire;
   logic                    fin;
   cnt_t                    go_len;
   cnt_t                    rx_cnt_n;
   idx_t                    go_idx;
   idx_t                    tx_idx;
   idx_t                    rx_idx;
   logic [SPI_MAX_CHAR-1:0] rx_nxt;

   always_comb begin
      busy    = (state == SPI_ST_BUSY);
      tx_fire = busy && (tx_neg ? i_neg_edge : i_pos_edge)
                && (tx_cnt != '0);
      rx_fire = busy && (rx_neg ? i_neg_edge : i_pos_edge)
                && (rx_cnt != '0);
      fin     = rx_fire && (rx_cnt == cnt_t'(1));
      // A zero length field encodes a full-width character
      go_len  = (i_char_len == '0) ? cnt_t'(SPI_MAX_CHAR)
                                   : cnt_t'(i_char_len);
      go_idx  = i_lsb ? '0 : idx_t'(go_len - 1'b1);
      tx_idx  = lsb ? idx_t'(len - tx_cnt)
                    : idx_t'(tx_cnt - 1'b1);
      rx_idx  = lsb ? idx_t'(len - rx_cnt)
                    : idx_t'(rx_cnt - 1'b1);
      rx_nxt  = rx_buf;
      if (rx_fire)
         rx_nxt[rx_idx] = i_miso;
      rx_cnt_n = rx_fire ? cnt_t'(rx_cnt - 1'b1) : rx_cnt;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= SPI_ST_IDLE;
         len        <= '0;
         tx_cnt     <= '0;
         rx_cnt     <= '0;
         lsb        <= 1'b0;
         tx_neg     <= 1'b0;
         rx_neg     <= 1'b0;
         tx_buf     <= '0;
         rx_buf     <= '0;
         o_tx_start <= 1'b0;
         o_last_clk <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_rx_data  <= '0;
         o_mosi     <= 1'b0;
      end else begin
         o_done <= 1'b0;
         unique case (state)
            SPI_ST_IDLE: begin
               if (i_go) begin
                  state      <= SPI_ST_BUSY;
                  len        <= go_len;
                  lsb        <= i_lsb;
                  tx_neg     <= i_tx_neg;
                  rx_neg     <= i_rx_neg;
                  tx_buf     <= i_tx_data;
                  rx_buf     <= '0;
                  rx_cnt     <= go_len;
                  o_busy     <= 1'b1;
                  o_tx_start <= 1'b1;
                  o_last_clk <= (go_len == cnt_t'(1));
                  if (i_tx_neg) begin
                     o_mosi <= i_tx_data[go_idx];
                     tx_cnt <= go_len - 1'b1;
                  end else begin
                     tx_cnt <= go_len;
                  end
               end
            end
            SPI_ST_BUSY: begin
               if (tx_fire) begin
                  o_mosi <= tx_buf[tx_idx];
                  tx_cnt <= tx_cnt - 1'b1;
               end
               rx_buf     <= rx_nxt;
               rx_cnt     <= rx_cnt_n;
               o_last_clk <= !fin && (rx_cnt_n == cnt_t'(1));
               if (fin) begin
                  state      <= SPI_ST_IDLE;
                  o_done     <= 1'b1;
                  o_rx_data  <= rx_nxt;
                  o_busy     <= 1'b0;
                  o_tx_start <= 1'b0;
               end
            end
            default: state <= SPI_ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_shift_ctrl.sv
// Directed bench for spi_shift_ctrl with an
// in-bench model of the clock generator strobes.
module tb_spi_shift_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        go;
   logic [4:0]  char_len;
   logic        lsb;
   logic        tx_neg;
   logic        rx_neg;
   logic        pos_edge;
   logic        neg_edge;
   logic [31:0] tx_data;
   logic        miso;
   logic        miso_val;
   logic        loop_en;
   logic        tx_start;
   logic        last_clk;
   logic        busy;
   logic        done;
   logic [31:0] rx_data;
   logic        mosi;

   int checks = 0;
   int errors = 0;

   assign miso = loop_en ? mosi : miso_val;

   always #5 clk = ~clk;

   spi_shift_ctrl dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_go       (go),
      .i_char_len (char_len),
      .i_lsb      (lsb),
      .i_tx_neg   (tx_neg),
      .i_rx_neg   (rx_neg),
      .i_pos_edge (pos_edge),
      .i_neg_edge (neg_edge),
      .i_tx_data  (tx_data),
      .i_miso     (miso),
      .o_tx_start (tx_start),
      .o_last_clk (last_clk),
      .o_busy     (busy),
      .o_done     (done),
      .o_rx_data  (rx_data),
      .o_mosi     (mosi)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Runs one character; strobes every 4 cycles
   // (pos first) while busy. seq collects o_mosi
   // at each receive strobe, first bit in the MSB.
   task automatic xfer(
      input  int          len,
      input  logic        l_lsb,
      input  logic        l_txn,
      input  logic        l_rxn,
      input  logic [31:0] data,
      input  logic        loop,
      input  int          go_again,
      input  int          abort_bits,
      output logic [31:0] seq,
      output int          dones,
      output int          lc_bad,
      output logic        lc_last,
      output logic        m_pre,
      output logic        m_post,
      output int          lat_got,
      output int          lat_exp
   );
      int   rxs;
      int   pcnt;
      int   donecyc;
      int   lastrx;
      logic p;
      logic n;
      logic r;
      logic taken;
      seq     = '0;
      dones   = 0;
      lc_bad  = 0;
      lc_last = 1'b0;
      m_pre   = 1'b0;
      m_post  = 1'b0;
      rxs     = 0;
      pcnt    = 0;
      donecyc = -1;
      lastrx  = -2;
      taken   = 1'b0;
      @(negedge clk);
      loop_en  = loop;
      char_len = len[4:0];
      lsb      = l_lsb;
      tx_neg   = l_txn;
      rx_neg   = l_rxn;
      tx_data  = data;
      go       = 1'b1;
      @(negedge clk);
      go       = 1'b0;
      char_len = 5'd3;
      lsb      = ~l_lsb;
      tx_data  = 32'h0;
      for (int k = 0; k < 2000; k++) begin
         if (done) begin
            dones++;
            donecyc = k;
         end
         if (last_clk && rxs != len - 1)
            lc_bad++;
         if (pcnt == 1 && !taken) begin
            m_post = mosi;
            taken  = 1'b1;
         end
         p = busy && (k % 8 == 3);
         n = busy && (k % 8 == 7);
         if (p && pcnt == 0)
            m_pre = mosi;
         if (p)
            pcnt++;
         r = l_rxn ? n : p;
         if (r) begin
            if (rxs == len - 1)
               lc_last = last_clk;
            seq    = {seq[30:0], mosi};
            rxs++;
            lastrx = k;
         end
         if (abort_bits > 0 && rxs == abort_bits) begin
            pos_edge = 1'b0;
            neg_edge = 1'b0;
            rst      = 1'b1;
            #1;
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_txst", 32'(tx_start), 32'd0);
            chk("rst_lclk", 32'(last_clk), 32'd0);
            chk("rst_rxd", rx_data, 32'h0);
            @(negedge clk);
            rst = 1'b0;
            break;
         end
         pos_edge = p;
         neg_edge = n;
         if (k == go_again) begin
            go      = 1'b1;
            tx_data = 32'h1234_5678;
         end else begin
            go      = 1'b0;
         end
         @(negedge clk);
         if (donecyc >= 0 && k >= donecyc + 20)
            break;
      end
      pos_edge = 1'b0;
      neg_edge = 1'b0;
      go       = 1'b0;
      lat_got  = donecyc;
      lat_exp  = lastrx + 1;
   endtask

   logic [31:0] seq;
   int          dones;
   int          lc_bad;
   logic        lc_last;
   logic        m_pre;
   logic        m_post;
   int          lat_got;
   int          lat_exp;

   initial begin
      rst      = 1'b1;
      go       = 1'b0;
      char_len = '0;
      lsb      = 1'b0;
      tx_neg   = 1'b0;
      rx_neg   = 1'b0;
      pos_edge = 1'b0;
      neg_edge = 1'b0;
      tx_data  = '0;
      miso_val = 1'b0;
      loop_en  = 1'b1;
      repeat (3) @(negedge clk);
      chk("r_busy", 32'(busy), 32'd0);
      chk("r_txst", 32'(tx_start), 32'd0);
      chk("r_lclk", 32'(last_clk), 32'd0);
      chk("r_done", 32'(done), 32'd0);
      chk("r_rxd", rx_data, 32'h0);
      chk("r_mosi", 32'(mosi), 32'd0);
      rst = 1'b0;

      // mode 0, MSB first, loopback
      xfer(8, 1'b0, 1'b1, 1'b0, 32'h0000_00A5, 1'b1,
           -1, 0, seq, dones, lc_bad, lc_last,
           m_pre, m_post, lat_got, lat_exp);
      chk("m0_seq", seq, 32'h0000_00A5);
      chk("m0_rxd", rx_data, 32'h0000_00A5);
      chk("m0_done", dones, 1);
      chk("m0_lcbad", lc_bad, 0);
      chk("m0_lclast", 32'(lc_last), 32'd1);
      chk("m0_lat", lat_got, lat_exp);

      // LSB first, upper data bits set
      xfer(4, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF3, 1'b1,
           -1, 0, seq, dones, lc_bad, lc_last,
           m_pre, m_post, lat_got, lat_exp);
      chk("lsb_seq", seq, 32'h0000_000C);
      chk("lsb_rxd", rx_data, 32'h0000_0003);
      chk("lsb_done", dones, 1);
      chk("lsb_lcbad", lc_bad, 0);

      // full 32-bit character
      xfer(32, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1,
           -1, 0, seq, dones, lc_bad, lc_last,
           m_pre, m_post, lat_got, lat_exp);
      chk("full_seq", seq, 32'hDEAD_BEEF);
      chk("full_rxd", rx_data, 32'hDEAD_BEEF);
      chk("full_done", dones, 1);
      chk("full_lat", lat_got, lat_exp);

      // go pulsed mid-transfer is ignored
      xfer(8, 1'b0, 1'b1, 1'b0, 32'h0000_003C, 1'b1,
           20, 0, seq, dones, lc_bad, lc_last,
           m_pre, m_post, lat_got, lat_exp);
      chk("bsy_rxd", rx_data, 32'h0000_003C);
      chk("bsy_done", dones, 1);
      chk("bsy_idle", 32'(busy), 32'd0);

      // reset after 3 bits
      xfer(8, 1'b0, 1'b1, 1'b0, 32'h0000_00FF, 1'b1,
           -1, 3, seq, dones, lc_bad, lc_last,
           m_pre, m_post, lat_got, lat_exp);
      chk("rst_nodone", dones, 0);
      chk("rst_mosi", 32'(mosi), 32'd0);

      // mode 1, miso held high
      miso_val = 1'b1;
      xfer(8, 1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b0,
           -1, 0, seq, dones, lc_bad, lc_last,
           m_pre, m_post, lat_got, lat_exp);
      chk("m1_pre", 32'(m_pre), 32'd0);
      chk("m1_post", 32'(m_post), 32'd1);
      chk("m1_seq", seq, 32'h0000_0080);
      chk("m1_rxd", rx_data, 32'h0000_00FF);
      chk("m1_done", dones, 1);
      chk("m1_lat", lat_got, lat_exp);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_shift_ctrl.md
# spi_shift_ctrl

Transfer controller and data shift register for the SPI master. It sits directly downstream of `spi_clk_gen` and consumes its `o_pos_edge`/`o_neg_edge` strobes to drive MOSI and sample MISO. It feeds back `o_tx_start` and `o_last_clk` so the clock generator runs exactly one character of serial clocks. Each character is 1..`SPI_MAX_CHAR` bits and can be MSB- or LSB-first.

## Interface
- `SPI_MAX_CHAR`, 32: maximum character length in bits; also the data width.
- `SPI_CHAR_LEN_BITS`, 5: width of `i_char_len` (log2 of `SPI_MAX_CHAR`).
- `i_clk` in 1: system clock; one clock domain.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_go` in 1: start request; sampled only in IDLE.
- `i_char_len` in `SPI_CHAR_LEN_BITS`: bits per character; 0 means `SPI_MAX_CHAR`.
- `i_lsb` in 1: 1 = LSB first, 0 = MSB first.
- `i_tx_neg` in 1: 1 = MOSI changes on `i_neg_edge`; 0 = on `i_pos_edge`.
- `i_rx_neg` in 1: 1 = MISO sampled on `i_neg_edge`; 0 = on `i_pos_edge`.
- `i_pos_edge` in 1: one-cycle strobe from `spi_clk_gen`.
- `i_neg_edge` in 1: one-cycle strobe from `spi_clk_gen`.
- `i_tx_data` in `SPI_MAX_CHAR`: character to send; latched at go.
- `i_miso` in 1: serial input.
- `o_tx_start` out 1: to `spi_clk_gen` `i_tx_start`; high throughout BUSY.
- `o_last_clk` out 1: to `spi_clk_gen` `i_last_clk`; high during the final SCLK period.
- `o_busy` out 1: transfer in progress.
- `o_done` out 1: one-cycle completion pulse.
- `o_rx_data` out `SPI_MAX_CHAR`: received character.
- `o_mosi` out 1: serial output.

## Operation
- **States:** IDLE and BUSY.
- **Reset:** state = IDLE; all outputs are 0; the shift register and counters are 0.
- **IDLE → BUSY on `i_go`:**
  - Latch `i_char_len` as `len` (0 maps to `SPI_MAX_CHAR`), and latch `i_lsb`, `i_tx_neg`, `i_rx_neg` and `i_tx_data`.
  - Set `rx_cnt` = `len`.
  - If the latched `tx_neg` = 1: drive the first bit on `o_mosi` in the same registered update and set `tx_cnt` = `len`−1.
  - Otherwise: set `tx_cnt` = `len`; the first bit goes out on the first `i_pos_edge`.
- **Transmit edge** (`i_neg_edge` if `tx_neg`, else `i_pos_edge`), when `tx_cnt` ≠ 0:
  - `o_mosi` takes bit `tx_cnt`−1 (MSB-first) or bit `len`−`tx_cnt` (LSB-first).
  - `tx_cnt` decrements.
- **Receive edge** (`i_neg_edge` if `rx_neg`, else `i_pos_edge`), when `rx_cnt` ≠ 0:
  - `i_miso` is written to bit `rx_cnt`−1 (MSB-first) or bit `len`−`rx_cnt` (LSB-first) of the receive register.
  - `rx_cnt` decrements.
- **`o_last_clk`:** high while BUSY and `rx_cnt` == 1.
- **Completion:** the receive edge that takes `rx_cnt` from 1 to 0 ends BUSY on that edge.
  - Next cycle: state = IDLE, `o_done` = 1 for one cycle, `o_rx_data` updated, `o_busy` = `o_tx_start` = 0.
- **`o_rx_data`:** unused upper bits (above `len`) read 0. Holds its value until the next completion.
- **`o_mosi`:** holds its last bit in IDLE.

## Timing
- `i_go` at cycle N → `o_busy`/`o_tx_start` = 1 at N+1. All outputs are registered.
- An `i_go` at cycle N with the transfer done at N+1 is ignored; `i_go` is only accepted while `o_busy` = 0.
- `i_go` is ignored while BUSY; configuration changes while BUSY have no effect.
- Edge strobes are single-cycle. Both strobes asserted in one cycle: each is processed independently.
- Strobes in IDLE are ignored.
- `o_last_clk` rises the cycle after the second-to-last receive edge. It is already high when `spi_clk_gen` begins the final SCLK period (divider ≥ 1).
- Total latency from `i_go` to `o_done` = 1 + cycles to `len` receive edges + 1.
- Reset mid-transfer: immediate (asynchronous) return to the reset state. No `o_done`. Partial receive data is discarded (`o_rx_data` = 0).

## Structure
- `SPI_MAX_CHAR` and `SPI_CHAR_LEN_BITS` defaults go in `define.v` next to `SPI_DIVIDER_LEN`.
- Add state encodings `SPI_ST_IDLE` = 1'b0 and `SPI_ST_BUSY` = 1'b1 to `define.v`.
- Single module, no sub-modules. Edge selection (tx/rx) is combinational logic inside.
- Top level instantiates `spi_shift_ctrl` alongside `spi_clk_gen`.

## Test plan
- **Mode 0, MSB-first:**
  - Stimulus: len = 8, `tx_neg` = 1, `rx_neg` = 0, `i_tx_data` = 0xA5, `i_miso` looped from `o_mosi`, divider = 6.
  - Response: `o_mosi` sequence 1,0,1,0,0,1,0,1; `o_rx_data` = 0x000000A5; exactly one `o_done`; `o_last_clk` high only during the 8th SCLK.
- **LSB-first:**
  - Stimulus: len = 4, `i_lsb` = 1, `i_tx_data` = 0x3 (`i_tx_data` bits above `len` carry other values).
  - Response: `o_mosi` = 1,1,0,0; loopback `o_rx_data` = 0x3.
- **Full length:** `i_char_len` = 0 with `i_tx_data` = 0xDEADBEEF in loopback → 32 bits; `o_rx_data` = 0xDEADBEEF.
- **Busy protection:** `i_go` pulsed mid-transfer with new data → ignored; the original character completes; one `o_done`.
- **Reset mid-transfer:** `i_rst` asserted after 3 bits → `o_busy`, `o_tx_start`, `o_last_clk`, `o_rx_data` = 0 immediately; a new `i_go` then completes normally.
- **Mode 1:** `tx_neg` = 0, `rx_neg` = 1, `i_miso` held 1, len = 8 → `o_rx_data` = 0xFF; first `o_mosi` change at the first `i_pos_edge`.
